// File: rtl/relu_stream_sequencer_if.sv
// Pixel-vector stream bundle between the conv engine, the activation sequencer and writeback.
// The sequencer takes the slave view; the producer/consumer side takes the master view.
interface relu_stream_sequencer_if #(
    parameter int DATA_W = 72
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/relu_stream_sequencer.sv
// Activation-stage frame controller: per-channel ReLU (or bypass) on a pixel-vector stream,
// counting pixels against a latched frame length and tagging the last vector.
module relu_stream_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int OUT_CHANNELS = 9,
    parameter int PIX_CNT_W    = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_start,
    input  logic                 cfg_relu_en,
    input  logic [PIX_CNT_W-1:0] cfg_num_pixels,
    output logic                 busy,
    output logic                 frame_done,
    relu_stream_sequencer_if.slave s
);
    localparam int VEC_W = OUT_CHANNELS * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 relu_en_q, relu_en_d;
    logic [PIX_CNT_W-1:0] num_pixels_q, num_pixels_d;
    logic [PIX_CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [VEC_W-1:0]     out_data_q, out_data_d;

    logic [PIX_CNT_W-1:0] acc_inc;
    logic [VEC_W-1:0]     act_data;
    logic                 in_ready;
    logic                 in_xfer;
    logic                 out_xfer;

    assign acc_inc  = acc_cnt_q + {{(PIX_CNT_W-1){1'b0}}, 1'b1};
    // Input is only taken when the output register is free or draining this cycle,
    // which gives full throughput without needing a skid buffer.
    assign in_ready = (state_q == RUN) && (acc_cnt_q < num_pixels_q)
                      && (!out_valid_q || s.out_ready);
    assign in_xfer  = s.in_valid && in_ready;
    assign out_xfer = out_valid_q && s.out_ready;

    assign s.in_ready  = in_ready;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_last  = out_last_q;

    always_comb begin
        act_data = '0;
        for (int c = 0; c < OUT_CHANNELS; c++) begin
            act_data[c*DATA_WIDTH +: DATA_WIDTH] =
                (relu_en_q && s.in_data[c*DATA_WIDTH + DATA_WIDTH - 1])
                    ? '0 : s.in_data[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            relu_en_q    <= 1'b0;
            num_pixels_q <= '0;
            acc_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            relu_en_q    <= relu_en_d;
            num_pixels_q <= num_pixels_d;
            acc_cnt_q    <= acc_cnt_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cfg_start) state_d = (cfg_num_pixels != '0) ? RUN : DONE;
            RUN:  if (out_xfer && out_last_q) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        relu_en_d    = relu_en_q;
        num_pixels_d = num_pixels_q;
        acc_cnt_d    = acc_cnt_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        if (state_q == IDLE && cfg_start) begin
            relu_en_d    = cfg_relu_en;
            num_pixels_d = cfg_num_pixels;
            acc_cnt_d    = '0;
        end
        if (in_xfer) begin
            acc_cnt_d   = acc_inc;
            out_valid_d = 1'b1;
            out_data_d  = act_data;
            out_last_d  = (acc_inc == num_pixels_q);
        end else if (s.out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_comb begin
        busy       = (state_q == RUN);
        frame_done = (state_q == DONE);
    end
endmodule

// File: tb/tb_relu_stream_sequencer.sv
// Directed bench for relu_stream_sequencer: ReLU/bypass values, framing, backpressure,
// zero-length pass, start-in-RUN, and async reset mid-pass.
module tb_relu_stream_sequencer;
    localparam int DW = 8;
    localparam int CH = 9;
    localparam int PW = 20;
    localparam int VW = DW * CH;

    typedef struct {
        logic          last;
        logic [VW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_start;
    logic          cfg_relu_en;
    logic [PW-1:0] cfg_num_pixels;
    logic          busy;
    logic          frame_done;

    relu_stream_sequencer_if #(.DATA_W(VW)) sif ();

    relu_stream_sequencer #(
        .DATA_WIDTH(DW), .OUT_CHANNELS(CH), .PIX_CNT_W(PW)
    ) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_relu_en(cfg_relu_en),
        .cfg_num_pixels(cfg_num_pixels), .busy(busy), .frame_done(frame_done), .s(sif)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errs   = 0;
    int            cyc    = 0;
    int            last_cyc = -100;
    int            out_cnt = 0;
    bit            done_seen = 0;
    bit            prev_done = 0;
    bit            in_xfer = 0;
    exp_t          exp_q[$];
    logic [VW-1:0] src[16];

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] rep(input logic [7:0] b);
        return {CH{b}};
    endfunction

    // Samples just after a negedge with inputs already driven; the transfers logged here
    // happen at the coming posedge. Returns at the following negedge.
    task automatic tick();
        exp_t e;
        #1;
        cyc++;
        if (frame_done) begin
            done_seen = 1;
            chk("done_lat", VW'(cyc - last_cyc), VW'(1));
            chk("busy_in_done", VW'(busy), VW'(0));
            chk("done_width", VW'(prev_done), VW'(0));
        end
        prev_done = frame_done;
        if (sif.out_valid && !sif.out_ready) chk("bp_in_ready", VW'(sif.in_ready), VW'(0));
        in_xfer = sif.in_valid && sif.in_ready;
        if (sif.out_valid && sif.out_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                chk("extra_out", VW'(1), VW'(0));
            end else begin
                e = exp_q.pop_front();
                chk("out_data", sif.out_data, e.data);
                chk("out_last", VW'(sif.out_last), VW'(e.last));
                if (sif.out_last) last_cyc = cyc;
            end
        end
        @(negedge clk);
    endtask

    task automatic start(input int num, input bit relu);
        cfg_start      = 1'b1;
        cfg_relu_en    = relu;
        cfg_num_pixels = PW'(num);
        out_cnt   = 0;
        done_seen = 0;
        tick();
        if (num == 0) last_cyc = cyc;
        cfg_start   = 1'b0;
        cfg_relu_en = ~relu;
        chk("busy_start", VW'(busy), VW'(num != 0));
    endtask

    task automatic stream(input int n, input bit tog, input int inj);
        int idx = 0;
        for (int c = 0; c < 200 && !done_seen; c++) begin
            sif.in_valid  = (idx < n);
            sif.in_data   = src[idx % 16];
            sif.out_ready = tog ? (c % 2 == 0) : 1'b1;
            cfg_start     = (c == inj);
            if (c == inj) cfg_num_pixels = PW'(3);
            tick();
            if (in_xfer) idx++;
        end
        cfg_start     = 1'b0;
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b1;
        chk("done_seen", VW'(done_seen), VW'(1));
        chk("out_count", VW'(out_cnt), VW'(n));
        chk("exp_empty", VW'(exp_q.size()), VW'(0));
    endtask

    initial begin
        reset = 1'b1; cfg_start = 1'b0; cfg_relu_en = 1'b0; cfg_num_pixels = '0;
        sif.in_valid = 1'b0; sif.in_data = '0; sif.out_ready = 1'b1;
        @(negedge clk); #1;
        chk("rst_busy", VW'(busy), VW'(0));
        chk("rst_done", VW'(frame_done), VW'(0));
        chk("rst_in_ready", VW'(sif.in_ready), VW'(0));
        chk("rst_out_valid", VW'(sif.out_valid), VW'(0));
        chk("rst_out_last", VW'(sif.out_last), VW'(0));
        chk("rst_out_data", sif.out_data, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 1: ReLU on, 4 vectors; negatives incl. 0x80 clamp to 0
        src[0] = rep(8'h05); src[1] = rep(8'hFB); src[2] = rep(8'h00); src[3] = rep(8'h80);
        exp_q.push_back('{1'b0, rep(8'h05)});
        exp_q.push_back('{1'b0, rep(8'h00)});
        exp_q.push_back('{1'b0, rep(8'h00)});
        exp_q.push_back('{1'b1, rep(8'h00)});
        start(4, 1'b1);
        stream(4, 1'b0, -1);

        // 2: bypass, negative samples pass through unchanged
        src[0] = {8'hFF, {8{8'h81}}}; src[1] = {8'h7F, {8{8'h81}}};
        exp_q.push_back('{1'b0, {8'hFF, {8{8'h81}}}});
        exp_q.push_back('{1'b1, {8'h7F, {8{8'h81}}}});
        start(2, 1'b0);
        stream(2, 1'b0, -1);

        // 3: 8 vectors under alternating out_ready
        for (int i = 0; i < 8; i++) begin
            src[i] = rep(8'(8'h10 + i));
            exp_q.push_back('{(i == 7), rep(8'(8'h10 + i))});
        end
        start(8, 1'b1);
        stream(8, 1'b1, -1);

        // 4: zero-length pass
        sif.in_valid = 1'b1;
        start(0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            chk("z_in_ready", VW'(sif.in_ready), VW'(0));
            chk("z_out_valid", VW'(sif.out_valid), VW'(0));
            tick();
        end
        sif.in_valid = 1'b0;
        chk("z_done_seen", VW'(done_seen), VW'(1));

        // 5: start with num=3 during a 5-pixel pass is ignored
        for (int i = 0; i < 5; i++) begin
            src[i] = rep(8'(8'h20 + i));
            exp_q.push_back('{(i == 4), rep(8'(8'h20 + i))});
        end
        start(5, 1'b1);
        stream(5, 1'b0, 2);

        // 6: async reset after 2 of 5 outputs, then a 1-pixel pass
        for (int i = 0; i < 5; i++) begin
            src[i] = rep(8'(8'h30 + i));
            exp_q.push_back('{(i == 4), rep(8'(8'h30 + i))});
        end
        start(5, 1'b1);
        begin
            int idx = 0;
            for (int c = 0; c < 50 && out_cnt < 2; c++) begin
                sif.in_valid = (idx < 5);
                sif.in_data  = src[idx];
                tick();
                if (in_xfer) idx++;
            end
        end
        chk("r_two_out", VW'(out_cnt), VW'(2));
        #2 reset = 1'b1;
        #1;
        chk("r_busy", VW'(busy), VW'(0));
        chk("r_in_ready", VW'(sif.in_ready), VW'(0));
        chk("r_out_valid", VW'(sif.out_valid), VW'(0));
        chk("r_out_last", VW'(sif.out_last), VW'(0));
        chk("r_out_data", sif.out_data, '0);
        chk("r_done", VW'(frame_done), VW'(0));
        exp_q.delete();
        sif.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        src[0] = rep(8'h9C);
        exp_q.push_back('{1'b1, rep(8'h00)});
        start(1, 1'b1);
        stream(1, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
